// File: rtl/wsram_ctrl_pkg.sv
// Shared definitions for the weight-SRAM subsystem.
// Holds the sequencer state encoding and the default bank geometry.
`ifndef SRAM_NUM
`define SRAM_NUM 8
`endif

package wsram_ctrl_pkg;

   localparam int CH_NUM_DEF = `SRAM_NUM;
   localparam int DW_DEF     = 72;
   localparam int AW_DEF     = 5;
   localparam int RD_LAT_DEF = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/wsram_bank.sv
// Single-port synchronous weight bank with active-low CEN/WEN and 1-cycle read.
// Behavioural model; the foundry macro takes its place in synthesis.
module wsram_bank
   import wsram_ctrl_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF,
   parameter int DEPTH = 2**AW
) (
   input  logic          clk,
   input  logic          cen,
   input  logic          wen,
   input  logic [AW-1:0] a,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem_r [DEPTH];

   // Array write or read; q holds its value on cycles without a read.
   always_ff @(posedge clk) begin
      if (!cen) begin
         if (!wen) begin
            mem_r[a] <= d;
         end else begin
            q <= mem_r[a];
         end
      end
   end

endmodule

// File: rtl/wsram_ctrl.sv
// Weight-SRAM sequencer: streams weights round-robin into CH_NUM banks and
// reads full rows back in bursts with a fixed-latency valid pipeline.
module wsram_ctrl
   import wsram_ctrl_pkg::*;
#(
   parameter int CH_NUM = CH_NUM_DEF,
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int DEPTH  = 2**AW,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic [AW-1:0]        load_base,
   input  logic [AW:0]          load_len,
   input  logic                 wr_valid,
   input  logic [DW-1:0]        wr_data,
   output logic                 wr_ready,
   input  logic                 rd_start,
   input  logic [AW-1:0]        rd_base,
   input  logic [AW:0]          rd_len,
   output logic                 rd_valid,
   output logic [CH_NUM*DW-1:0] rd_data,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   state_e                state_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  wr_ready_r;
   logic [AW-1:0]         base_r;
   logic [AW:0]           len_r;
   logic [AW:0]           row_cnt_r;
   logic [CW-1:0]         ch_cnt_r;
   logic [1:0]            drain_cnt_r;
   logic                  v1_r;
   logic [CH_NUM*DW-1:0]  hold_r;

   logic                  wr_acc_s;
   logic                  last_row_s;
   logic                  wen_s;
   logic [AW-1:0]         addr_s;
   logic [CH_NUM-1:0]     cen_s;
   logic [CH_NUM*DW-1:0]  q_s;

   // Bank strobes: only the addressed bank is enabled on a write, all banks on a read issue.
   always_comb begin
      wr_acc_s   = wr_valid & wr_ready_r;
      wen_s      = ~wr_acc_s;
      last_row_s = (row_cnt_r == (len_r - 1'b1));
      addr_s     = base_r + row_cnt_r[AW-1:0];
      cen_s      = '1;
      for (int i = 0; i < CH_NUM; i++) begin
         if (wr_acc_s && (ch_cnt_r == CW'(i))) begin
            cen_s[i] = 1'b0;
         end else if (state_r == ST_READ) begin
            cen_s[i] = 1'b0;
         end else begin
            cen_s[i] = 1'b1;
         end
      end
   end

   // Sequencer FSM with counters and registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         wr_ready_r  <= 1'b0;
         base_r      <= '0;
         len_r       <= '0;
         row_cnt_r   <= '0;
         ch_cnt_r    <= '0;
         drain_cnt_r <= 2'd0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               ch_cnt_r    <= '0;
               row_cnt_r   <= '0;
               drain_cnt_r <= 2'd0;
               if (load_start) begin
                  base_r <= load_base;
                  len_r  <= load_len;
                  if (load_len == '0) begin
                     done_r <= 1'b1;
                  end else begin
                     state_r    <= ST_LOAD;
                     busy_r     <= 1'b1;
                     wr_ready_r <= 1'b1;
                  end
               end else if (rd_start) begin
                  base_r <= rd_base;
                  len_r  <= rd_len;
                  if (rd_len == '0) begin
                     done_r <= 1'b1;
                  end else begin
                     state_r <= ST_READ;
                     busy_r  <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (wr_acc_s) begin
                  if (ch_cnt_r == CW'(CH_NUM - 1)) begin
                     ch_cnt_r <= '0;
                     if (last_row_s) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        wr_ready_r <= 1'b0;
                        done_r     <= 1'b1;
                     end else begin
                        row_cnt_r <= row_cnt_r + 1'b1;
                     end
                  end else begin
                     ch_cnt_r <= ch_cnt_r + 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (last_row_s) begin
                  state_r <= ST_DRAIN;
               end else begin
                  row_cnt_r <= row_cnt_r + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt_r == 2'(RD_LAT - 1)) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r + 1'b1;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               wr_ready_r <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_bank
      wsram_bank #(
         .DW    (DW),
         .AW    (AW),
         .DEPTH (DEPTH)
      ) u_bank (
         .clk (clk),
         .cen (cen_s[g]),
         .wen (wen_s),
         .a   (addr_s),
         .d   (wr_data),
         .q   (q_s[(g+1)*DW-1 -: DW])
      );
   end

   // First valid stage tracks the bank read; hold_r keeps the last row so rd_data never glitches.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r   <= 1'b0;
         hold_r <= '0;
      end else begin
         v1_r <= (state_r == ST_READ);
         if (v1_r) begin
            hold_r <= q_s;
         end
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic v2_r;

      // Extra output stage: hold_r becomes the output register itself.
      always_ff @(posedge clk) begin
         if (rst) begin
            v2_r <= 1'b0;
         end else begin
            v2_r <= v1_r;
         end
      end

      assign rd_valid = v2_r;
      assign rd_data  = hold_r;
   end else begin : g_lat1
      assign rd_valid = v1_r;
      assign rd_data  = v1_r ? q_s : hold_r;
   end

   assign wr_ready = wr_ready_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule

// File: tb/tb_wsram_ctrl.sv
// Scoreboard bench for wsram_ctrl: one RD_LAT=1 and one RD_LAT=2 instance
// share all stimulus; expected rows come from a bench-side memory model.
module tb_wsram_ctrl;

   localparam int CH  = 8;
   localparam int DW  = 72;
   localparam int AW  = 5;
   localparam int DEP = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            load_start = 1'b0;
   logic [AW-1:0]   load_base = '0;
   logic [AW:0]     load_len = '0;
   logic            wr_valid = 1'b0;
   logic [DW-1:0]   wr_data = '0;
   logic            rd_start = 1'b0;
   logic [AW-1:0]   rd_base = '0;
   logic [AW:0]     rd_len = '0;

   logic            wr_ready1, rd_valid1, busy1, done1;
   logic            wr_ready2, rd_valid2, busy2, done2;
   logic [CH*DW-1:0] rd_data1, rd_data2;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int vcnt1 = 0, vcnt2 = 0, rcnt1 = 0, rcnt2 = 0, vf1 = 0, vf2 = 0;
   int dcnt1 = 0, dcnt2 = 0, dcyc1 = 0, dcyc2 = 0;
   bit pv1 = 1'b0, pv2 = 1'b0, rst_q = 1'b0, mon_en = 1'b0;
   logic [CH*DW-1:0] last1 = '0, last2 = '0;
   logic [CH*DW-1:0] q1[$];
   logic [CH*DW-1:0] q2[$];
   logic [DW-1:0] mdl [CH][DEP];

   wsram_ctrl #(.CH_NUM(CH), .DW(DW), .AW(AW), .DEPTH(DEP), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base), .load_len(load_len),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready1),
      .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
      .rd_valid(rd_valid1), .rd_data(rd_data1), .busy(busy1), .done(done1)
   );

   wsram_ctrl #(.CH_NUM(CH), .DW(DW), .AW(AW), .DEPTH(DEP), .RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base), .load_len(load_len),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready2),
      .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
      .rd_valid(rd_valid2), .rd_data(rd_data2), .busy(busy2), .done(done2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [639:0] act, input logic [639:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] mkword(input int seed, input int k);
      logic [DW-1:0] w;
      if (seed == 0) begin
         w = DW'(k + 1);
      end else begin
         w = {8'(seed), 32'(k * 32'h9E3779B1), 32'(k ^ (seed << 8))};
      end
      return w;
   endfunction

   function automatic logic [CH*DW-1:0] row_of(input int r);
      logic [CH*DW-1:0] row;
      for (int i = 0; i < CH; i++) row[i*DW +: DW] = mdl[i][r];
      return row;
   endfunction

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   // Output monitor: pops expected rows, checks hold behaviour, logs valid/done timing.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_q) begin
            q1.delete();
            q2.delete();
            last1 = '0;
            last2 = '0;
         end
         if (rd_valid1) begin
            vcnt1++;
            if (!pv1) begin rcnt1++; vf1 = cyc; end
            if (q1.size() > 0) check("rd1_row", rd_data1, q1.pop_front());
            last1 = rd_data1;
         end else begin
            check("rd1_hold", rd_data1, last1);
         end
         if (rd_valid2) begin
            vcnt2++;
            if (!pv2) begin rcnt2++; vf2 = cyc; end
            if (q2.size() > 0) check("rd2_row", rd_data2, q2.pop_front());
            last2 = rd_data2;
         end else begin
            check("rd2_hold", rd_data2, last2);
         end
         pv1 = rd_valid1;
         pv2 = rd_valid2;
         if (done1) begin dcnt1++; dcyc1 = cyc; end
         if (done2) begin dcnt2++; dcyc2 = cyc; end
      end
   end

   task automatic do_load(input int b, input int len, input int seed, input int stall_at,
                          input bit rd_also, input bit rd_mid);
      int bad;
      int v0;
      int d0;
      bad = 0;
      v0 = vcnt1 + vcnt2;
      d0 = dcnt1;
      load_start = 1'b1;
      load_base  = AW'(b);
      load_len   = (AW+1)'(len);
      if (rd_also) begin
         rd_start = 1'b1;
         rd_base  = '0;
         rd_len   = 6'd4;
      end
      tick;
      load_start = 1'b0;
      rd_start   = 1'b0;
      if (len == 0) begin
         check("ld0_done", {done1, done2, busy1, busy2}, 4'b1100);
      end else begin
         for (int k = 0; k < len * CH; k++) begin
            if (k == stall_at) begin
               repeat (5) begin
                  wr_valid = 1'b0;
                  bad += int'((wr_ready1 !== 1'b1) || (wr_ready2 !== 1'b1) || (done1 !== 1'b0));
                  tick;
               end
            end
            wr_valid = 1'b1;
            wr_data  = mkword(seed, k);
            rd_start = rd_mid && (k == 3);
            bad += int'((wr_ready1 !== 1'b1) || (wr_ready2 !== 1'b1) || (busy1 !== 1'b1) || (done1 !== 1'b0));
            mdl[k % CH][(b + k / CH) % DEP] = wr_data;
            tick;
         end
         wr_valid = 1'b0;
         rd_start = 1'b0;
         check("ld_handshake", 32'(bad), 32'd0);
         check("ld_done", {done1, done2, wr_ready1, wr_ready2, busy1}, 5'b11000);
      end
      check("ld_done_cnt", 32'(dcnt1 - d0), 32'd1);
      tick;
      check("ld_no_valid", 32'(vcnt1 + vcnt2 - v0), 32'd0);
   endtask

   task automatic do_read(input int b, input int len, input bit rst_at3);
      int t0, v1b, v2b, r1b, r2b, d1b, d2b;
      t0 = cyc; v1b = vcnt1; v2b = vcnt2; r1b = rcnt1; r2b = rcnt2; d1b = dcnt1; d2b = dcnt2;
      rd_start = 1'b1;
      rd_base  = AW'(b);
      rd_len   = (AW+1)'(len);
      for (int r = 0; r < len; r++) begin
         q1.push_back(row_of((b + r) % DEP));
         q2.push_back(row_of((b + r) % DEP));
      end
      tick;
      rd_start = 1'b0;
      if (rst_at3) begin
         tick;
         tick;
         rst = 1'b1;
         tick;
         check("rst_valid", {rd_valid1, rd_valid2}, 2'b00);
         check("rst_busy", {busy1, busy2}, 2'b00);
         rst = 1'b0;
         repeat (12) tick;
         check("rst_v1_cnt", 32'(vcnt1 - v1b), 32'd2);
         check("rst_v2_cnt", 32'(vcnt2 - v2b), 32'd1);
         check("rst_no_done", 32'(dcnt1 - d1b + dcnt2 - d2b), 32'd0);
      end else begin
         repeat (len + 4) tick;
         check("rd1_vcnt", 32'(vcnt1 - v1b), 32'(len));
         check("rd2_vcnt", 32'(vcnt2 - v2b), 32'(len));
         check("rd1_runs", 32'(rcnt1 - r1b), (len > 0) ? 32'd1 : 32'd0);
         check("rd2_runs", 32'(rcnt2 - r2b), (len > 0) ? 32'd1 : 32'd0);
         check("rd1_done_cnt", 32'(dcnt1 - d1b), 32'd1);
         check("rd2_done_cnt", 32'(dcnt2 - d2b), 32'd1);
         check("rd1_done_cyc", 32'(dcyc1 - t0), (len > 0) ? 32'(len + 2) : 32'd1);
         check("rd2_done_cyc", 32'(dcyc2 - t0), (len > 0) ? 32'(len + 3) : 32'd1);
         if (len > 0) begin
            check("rd1_first", 32'(vf1 - t0), 32'd2);
            check("rd2_first", 32'(vf2 - t0), 32'd3);
         end
         check("rd_idle", {busy1, busy2}, 2'b00);
      end
   endtask

   initial begin
      repeat (3) tick;
      mon_en = 1'b1;
      rst = 1'b0;
      tick;
      check("reset_outs1", {wr_ready1, rd_valid1, busy1, done1}, 4'b0000);
      check("reset_outs2", {wr_ready2, rd_valid2, busy2, done2}, 4'b0000);
      check("reset_rd_data1", rd_data1, '0);
      check("reset_rd_data2", rd_data2, '0);

      // Known fill of every row, then the basic 0x1..0x10 round trip.
      do_load(0, 32, 7, -1, 1'b0, 1'b0);
      do_load(0, 2, 0, -1, 1'b0, 1'b0);
      check("basic_r0b5", 72'(row_of(0) >> (5 * DW)), 72'd6);
      check("basic_r1b2", 72'(row_of(1) >> (2 * DW)), 72'd11);
      do_read(0, 2, 1'b0);

      // Wrap-around rows 31 -> 0, then untouched rows.
      do_load(31, 2, 2, -1, 1'b0, 1'b0);
      do_read(31, 2, 1'b0);
      do_read(1, 30, 1'b0);

      // Stall mid-row and ignored rd_start during the burst.
      do_load(4, 3, 3, 11, 1'b0, 1'b1);
      do_read(4, 3, 1'b0);

      // Zero length and simultaneous starts.
      do_load(10, 0, 4, -1, 1'b0, 1'b0);
      do_read(12, 0, 1'b0);
      do_load(20, 1, 5, -1, 1'b1, 1'b0);
      do_read(20, 4, 1'b0);

      // Reset during an 8-row read, then the data must be intact.
      do_read(0, 8, 1'b1);
      do_read(0, 32, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wsram_ctrl.md
Name: wsram_ctrl

Overview:
Parametrised weight-SRAM subsystem: CH_NUM parallel single-port banks, each DW bits wide and DEPTH deep, plus a sequencer FSM.
- Loads weights from a serial valid/ready stream, round-robin across banks.
- Reads back full rows (all banks in parallel) in bursts with a fixed-latency valid pipeline.
- Sits between the weight DMA/loader and the PE array's weight input, replacing hand-driven per-bank CEN/WEN/A control.

Parameters:
CH_NUM, 8, number of banks (channels).
DW, 72, bank word width in bits.
AW, 5, bank address width.
DEPTH, 32, rows per bank; must equal 2**AW.
RD_LAT, 1, bank read latency in cycles; 1 or 2 (2 adds an output register).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous active-high reset.
load_start  in  1  one-cycle pulse; begin load burst (sampled only in IDLE).
load_base  in  AW  first row of load.
load_len  in  AW+1  rows to load (each row = CH_NUM words); 0..DEPTH.
wr_valid  in  1  stream word valid.
wr_data  in  DW  stream word.
wr_ready  out  1  stream ready; word accepted when wr_valid && wr_ready.
rd_start  in  1  one-cycle pulse; begin read burst (sampled only in IDLE).
rd_base  in  AW  first row of read.
rd_len  in  AW+1  rows to read; 0..DEPTH.
rd_valid  out  1  rd_data holds one valid row this cycle.
rd_data  out  CH_NUM*DW  row data; bank i occupies bits [(i+1)*DW-1 -: DW].
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset values: wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0; state=IDLE; all counters 0. Bank contents are not reset.
- States: IDLE, LOAD, READ, DRAIN.
- IDLE:
  - load_start -> LOAD; latch base/len; ch_cnt=0; row_cnt=0.
  - rd_start -> READ.
  - Both pulses in the same cycle: load wins; rd_start is dropped.
  - Starts seen outside IDLE are ignored.
- LOAD:
  - wr_ready=1.
  - Each accepted word is written to bank ch_cnt at row (base+row_cnt) mod DEPTH, in the same cycle as acceptance.
  - ch_cnt increments; on wrap to 0, row_cnt increments.
  - After the last word (row_cnt==len-1, ch_cnt==CH_NUM-1 accepted) -> IDLE, done=1 that cycle+1, wr_ready=0 from the next cycle.
  - wr_valid low stalls the burst with no writes. There is no timeout.
- READ:
  - Issues one row read per cycle: all banks enabled, address (base+row_cnt) mod DEPTH.
  - After the last issue -> DRAIN.
- DRAIN:
  - Waits RD_LAT cycles, then -> IDLE with done=1.
  - rd_valid asserts exactly RD_LAT cycles after each issue, for len consecutive cycles.
  - There is no output backpressure; the consumer must accept every row.
- len==0 (either mode): no bank access, no rd_valid; done pulses one cycle after the start is sampled; state returns to IDLE.
- Address arithmetic is modulo DEPTH: base=30, len=4, DEPTH=32 touches rows 30, 31, 0, 1.
- rd_data holds its last value when rd_valid=0.
- Bank enable (CEN) is active low; it is deasserted (high) on every cycle with no access, to save power.
- Reset mid-burst: on the next edge the FSM goes to IDLE, the valid pipeline is flushed (rd_valid=0), and no done pulse is produced. Partially written rows keep whatever was already written.
- Write and read are never simultaneous, so there is no single-port conflict.

Decomposition:
- Shared package: localparams for state encodings (IDLE=2'd0, LOAD=2'd1, READ=2'd2, DRAIN=2'd3) and CH_NUM/DW/AW defaults, kept consistent with the global SRAM_NUM macro.
- One sub-module: wsram_bank.
  - Parametrised (DW, AW) single-port synchronous SRAM.
  - Active-low CEN/WEN, 1-cycle read.
  - Behavioural model for simulation, swapped for the foundry macro in synthesis.
- wsram_ctrl instantiates CH_NUM of them in a generate loop and adds the optional RD_LAT=2 output register.

Test Plan:
- Basic round trip (defaults): load base=0, len=2 with 16 words 0x1..0x10 -> wr_ready high 16 cycles, done pulse. Then read base=0, len=2 -> rd_valid 2 cycles starting 1 cycle after first issue; row0 bank i = i+1, row1 bank i = i+9; done pulse.
- Wrap-around: load base=31, len=2 -> rows 31 and 0 written. Read base=31, len=2 returns them in order; rows 1..30 unchanged from a prior known fill.
- Stall: during load, wr_valid low for 5 cycles mid-row -> ch_cnt/row_cnt frozen, no writes; final contents match an unstalled load; done delayed by exactly 5 cycles.
- Zero length / conflict: load_len=0 -> done 1 cycle later, no write. load_start and rd_start same cycle -> LOAD only. rd_start while busy -> ignored; no extra rd_valid.
- Reset mid-read: rst asserted on 3rd cycle of an 8-row read -> rd_valid=0 and busy=0 the next cycle, no done. A subsequent read returns intact data.
- RD_LAT=2 build: read len=4 -> first rd_valid 2 cycles after first issue, 4 contiguous valids, done after the last.
